regfile_dump_reader: RTL and testbench
======================================

# regfile_dump_reader

Debug read-out engine for the SoC register bank: on a start request it walks a contiguous range of architectural registers through one asynchronous read port of the register file, latches each 32-bit word, and streams it out as four bytes (LSB first) on a valid/ready byte interface toward the debug UART/host link. It sits beside the core's register file as the reading end of its read port, and its byte stream is consumed by the debug transmitter.

## Interface
- FIRST_REG, 0, first register index dumped (0..31)
- LAST_REG, 31, last register index dumped (FIRST_REG..31); elaboration error if LAST_REG < FIRST_REG
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- Start  in  1  dump request; sampled only in IDLE
- Busy  out  1  high in every state except IDLE
- Done  out  1  single-cycle pulse after the last byte of LAST_REG is accepted
- RegAddr  out  5  register file read address (drives Rs1 or Rs2 of the bank)
- RegData  in  32  register file read data (combinational response to RegAddr)
- OutValid  out  1  byte available on OutData
- OutReady  in  1  downstream accepts byte when OutValid & OutReady
- OutData  out  8  current byte

## Operation
- States: IDLE, LOAD, SEND, DONE.
- IDLE: Busy=0, OutValid=0, RegAddr=0. Start=1 -> idx<=FIRST_REG, go LOAD.
- LOAD: RegAddr=idx; at rising edge capture RegData into 32-bit shift register, byte_cnt<=0, go SEND. OutValid=0.
- SEND: RegAddr=idx (held), OutValid=1, OutData=shift[7:0]. On handshake: shift>>=8, byte_cnt++. Handshake with byte_cnt==3: if idx==LAST_REG go DONE, else idx++ and go LOAD.
- DONE: Done=1 for exactly one cycle, Busy=1, then IDLE.
- Without handshake, OutData and OutValid stay stable (no retraction, no data change).
- Word is snapshotted in LOAD; later writes to that register do not affect bytes already in flight. Coherent full snapshot requires the core stalled; this block does not enforce it.
- Register 0 is streamed as read (bank returns 0).
- Start during Busy is ignored, not queued.
- rst=1 in any state, including mid-word: next state IDLE, idx=0, byte_cnt=0, shift=0; no partial word completion, no Done pulse.
- Reset values: Busy=0, Done=0, OutValid=0, OutData=0, RegAddr=0.

## Timing
- Start sampled at edge t -> LOAD during cycle t+1 -> first byte valid cycle t+2.
- Per register: 1 LOAD cycle + 4 SEND handshakes; with OutReady tied high, 5 cycles per register.
- Full 32-register dump with OutReady=1: 160 cycles from LOAD entry to DONE, Done at cycle t+161, Busy falls at t+162.
- Back-pressure stretches SEND only; LOAD is never skipped or stalled.
- RegData must settle within the LOAD cycle (bank read is combinational; bank writes on falling edge are visible at next rising edge).

## Structure
- Shared debug package: state encoding constants (IDLE/LOAD/SEND/DONE), REG_IDX_W=5, WORD_W=32, BYTE_W=8, BYTES_PER_WORD=4.
- One natural sub-module: word_byte_serializer (load strobe + 32-bit word in, valid/ready byte out, last-byte flag); FSM and index counter stay in the top.

## Test plan
- Bank preloaded x1=0x11223344, FIRST_REG=LAST_REG=1, OutReady=1, Start pulse -> bytes 0x44,0x33,0x22,0x11 on consecutive cycles from t+2, Done at t+6, RegAddr=1 throughout.
- Default range, bank[i]=i*0x01010101, OutReady=1 -> 128 bytes, x0 gives 00 00 00 00, x31 gives 1F 1F 1F 1F, Done exactly 161 cycles after Start.
- FIRST_REG=2, LAST_REG=3, OutReady toggling 1-0-1-0 -> OutData stable across stalls, 8 bytes in order, no duplicates or drops.
- Write x5<=0xDEADBEEF after LOAD of x5 while its bytes stall -> streamed bytes are the old value; next dump returns EF BE AD DE.
- Start pulsed again mid-dump -> ignored, single Done; rst asserted after second byte of x3 -> next cycle Busy=0, OutValid=0, no Done; fresh Start restarts at FIRST_REG.

Source files
------------

// File: rtl/regfile_dump_reader_pkg.sv
// -----------------------------------------------------------------------------
// regfile_dump_reader_pkg
// Shared debug definitions for the register-bank dump reader. It holds the
// dump FSM state encoding, the datapath widths and a small helper for the
// byte counter.
// -----------------------------------------------------------------------------
package regfile_dump_reader_pkg;

  localparam int REG_IDX_W      = 5;
  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } dump_state_t;

  // True when the byte counter points at the most significant byte of a word.
  function automatic logic is_last_byte(input logic [BYTE_CNT_W-1:0] cnt);
    return (cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));
  endfunction

endpackage

// File: rtl/regfile_dump_reader_word_byte_serializer.sv
// -----------------------------------------------------------------------------
// word_byte_serializer
// Snapshots a 32-bit word on a load strobe and presents it LSB-first as four
// bytes on a valid/ready interface. The byte on offer and the valid flag only
// change on a handshake, so a stalled consumer always sees stable data.
//
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-high reset (clears snapshot and counter)
//   load   in   capture word, restart at byte 0, raise valid
//   word   in   32-bit word to serialise
//   ready  in   consumer accepts the current byte
//   valid  out  a byte is on offer
//   data   out  current byte (low byte of the snapshot)
//   last   out  the byte on offer is the fourth of the word
//   fire   out  handshake this cycle (valid & ready)
// -----------------------------------------------------------------------------
module word_byte_serializer
  import regfile_dump_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  input  logic              ready,
  output logic              valid,
  output logic [BYTE_W-1:0] data,
  output logic              last,
  output logic              fire
);

  logic [WORD_W-1:0]     shift_r;
  logic [BYTE_CNT_W-1:0] byte_cnt_r;
  logic                  valid_r;

  assign fire  = valid_r & ready;
  assign last  = is_last_byte(byte_cnt_r);
  assign valid = valid_r;
  assign data  = shift_r[BYTE_W-1:0];

  // Snapshot register, byte counter and valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r    <= {WORD_W{1'b0}};
      byte_cnt_r <= {BYTE_CNT_W{1'b0}};
      valid_r    <= 1'b0;
    end else if (load) begin
      shift_r    <= word;
      byte_cnt_r <= {BYTE_CNT_W{1'b0}};
      valid_r    <= 1'b1;
    end else if (fire) begin
      shift_r    <= shift_r >> BYTE_W;
      byte_cnt_r <= byte_cnt_r + BYTE_CNT_W'(1);
      // The word is exhausted after its fourth byte; the next load re-arms valid.
      valid_r    <= ~last;
    end else begin
      shift_r    <= shift_r;
      byte_cnt_r <= byte_cnt_r;
      valid_r    <= valid_r;
    end
  end

endmodule

// File: rtl/regfile_dump_reader.sv
// -----------------------------------------------------------------------------
// regfile_dump_reader
// Debug read-out engine for the register bank. On Start it walks registers
// FIRST_REG..LAST_REG through one combinational read port, snapshots each
// word and streams it LSB-first as bytes toward the debug transmitter.
//
// Parameters:
//   FIRST_REG  first register index dumped (0..31)
//   LAST_REG   last register index dumped (FIRST_REG..31)
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   Start     in   dump request, only honoured while idle
//   Busy      out  high in every state except IDLE
//   Done      out  one-cycle pulse after the last byte of LAST_REG is taken
//   RegAddr   out  register file read address
//   RegData   in   register file read data (combinational on RegAddr)
//   OutValid  out  byte available on OutData
//   OutReady  in   downstream accepts byte when OutValid & OutReady
//   OutData   out  current byte
// -----------------------------------------------------------------------------
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Start,
  output logic                 Busy,
  output logic                 Done,
  output logic [REG_IDX_W-1:0] RegAddr,
  input  logic [WORD_W-1:0]    RegData,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [BYTE_W-1:0]    OutData
);

  if (FIRST_REG < 0 || FIRST_REG > 31) begin : g_bad_first
    $error("regfile_dump_reader: FIRST_REG must be within 0..31");
  end
  if (LAST_REG < FIRST_REG || LAST_REG > 31) begin : g_bad_last
    $error("regfile_dump_reader: LAST_REG must be within FIRST_REG..31");
  end

  localparam logic [REG_IDX_W-1:0] FIRST_IDX = REG_IDX_W'(FIRST_REG);
  localparam logic [REG_IDX_W-1:0] LAST_IDX  = REG_IDX_W'(LAST_REG);

  dump_state_t          state_r;
  dump_state_t          state_next_s;
  logic [REG_IDX_W-1:0] idx_r;
  logic [REG_IDX_W-1:0] idx_next_s;
  logic [REG_IDX_W-1:0] addr_next_s;
  logic                 busy_r;
  logic                 done_r;
  logic [REG_IDX_W-1:0] reg_addr_r;
  logic                 load_s;
  logic                 ser_last_s;
  logic                 ser_fire_s;

  word_byte_serializer u_serializer (
    .clk   (clk),
    .rst   (rst),
    .load  (load_s),
    .word  (RegData),
    .ready (OutReady),
    .valid (OutValid),
    .data  (OutData),
    .last  (ser_last_s),
    .fire  (ser_fire_s)
  );

  // Next-state, register index and serializer load strobe.
  always_comb begin
    state_next_s = state_r;
    idx_next_s   = idx_r;
    load_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (Start) begin
          state_next_s = ST_LOAD;
          idx_next_s   = FIRST_IDX;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // RegAddr already holds idx, so RegData is the word to snapshot.
        load_s       = 1'b1;
        state_next_s = ST_SEND;
      end
      ST_SEND: begin
        if (ser_fire_s && ser_last_s) begin
          if (idx_r == LAST_IDX) begin
            state_next_s = ST_DONE;
          end else begin
            idx_next_s   = idx_r + REG_IDX_W'(1);
            state_next_s = ST_LOAD;
          end
        end else begin
          state_next_s = ST_SEND;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // The read address is only driven while a word is being fetched or sent.
  always_comb begin
    addr_next_s = {REG_IDX_W{1'b0}};
    if (state_next_s == ST_LOAD || state_next_s == ST_SEND) begin
      addr_next_s = idx_next_s;
    end else begin
      addr_next_s = {REG_IDX_W{1'b0}};
    end
  end

  // State, index and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      idx_r      <= {REG_IDX_W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      reg_addr_r <= {REG_IDX_W{1'b0}};
    end else begin
      state_r    <= state_next_s;
      idx_r      <= idx_next_s;
      busy_r     <= (state_next_s != ST_IDLE);
      done_r     <= (state_next_s == ST_DONE);
      reg_addr_r <= addr_next_s;
    end
  end

  assign Busy    = busy_r;
  assign Done    = done_r;
  assign RegAddr = reg_addr_r;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// -----------------------------------------------------------------------------
// tb_regfile_dump_reader
// Three instances share a behavioural register bank: FIRST=LAST=1, the full
// 0..31 range, and 2..3. Expected bytes are queued from the bank contents
// when each dump is started and popped on every observed handshake.
// -----------------------------------------------------------------------------
module tb_regfile_dump_reader;

  typedef struct packed {
    logic [7:0] data;
    logic [4:0] addr;
  } sb_item_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ready, start0, start1, start2;
  logic        busy0, busy1, busy2, done0, done1, done2;
  logic        v0, v1, v2;
  logic [7:0]  d0, d1, d2;
  logic [4:0]  addr0, addr1, addr2;
  logic [31:0] rd0, rd1, rd2;
  logic [31:0] bank [32];

  assign rd0 = bank[addr0];
  assign rd1 = bank[addr1];
  assign rd2 = bank[addr2];

  regfile_dump_reader #(.FIRST_REG(1), .LAST_REG(1)) u_one (
    .clk(clk), .rst(rst), .Start(start0), .Busy(busy0), .Done(done0),
    .RegAddr(addr0), .RegData(rd0), .OutValid(v0), .OutReady(ready), .OutData(d0));

  regfile_dump_reader u_full (
    .clk(clk), .rst(rst), .Start(start1), .Busy(busy1), .Done(done1),
    .RegAddr(addr1), .RegData(rd1), .OutValid(v1), .OutReady(ready), .OutData(d1));

  regfile_dump_reader #(.FIRST_REG(2), .LAST_REG(3)) u_pair (
    .clk(clk), .rst(rst), .Start(start2), .Busy(busy2), .Done(done2),
    .RegAddr(addr2), .RegData(rd2), .OutValid(v2), .OutReady(ready), .OutData(d2));

  int         sel = 1;
  logic       s_busy, s_done, s_valid;
  logic [7:0] s_data;
  logic [4:0] s_addr;

  always_comb begin
    case (sel)
      0:       begin s_busy = busy0; s_done = done0; s_valid = v0; s_data = d0; s_addr = addr0; end
      1:       begin s_busy = busy1; s_done = done1; s_valid = v1; s_data = d1; s_addr = addr1; end
      default: begin s_busy = busy2; s_done = done2; s_valid = v2; s_data = d2; s_addr = addr2; end
    endcase
  end

  sb_item_t   sb_q[$];
  int         tests = 0;
  int         fails = 0;
  int         k, done_count, done_k, last_busy_k, first_hs_k, hs_count;
  int         ready_mode = 0;   // 0: ready high, 1: toggle every cycle, 2: manual
  logic       prev_stall = 1'b0;
  logic       prev_rst = 1'b1;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: monitor the selected instance at the falling edge, then
  // advance past the rising edge and update ready.
  task automatic cycle();
    sb_item_t it;
    @(negedge clk);
    if (prev_stall && !prev_rst) begin
      check("hold_valid", 32'(s_valid), 32'd1);
      check("hold_data", 32'(s_data), 32'(prev_data));
    end
    if (s_valid && ready) begin
      check("sb_empty_at_byte", 32'(sb_q.size() == 0), 32'd0);
      if (sb_q.size() != 0) begin
        it = sb_q.pop_front();
        check("byte", 32'(s_data), 32'(it.data));
        check("regaddr", 32'(s_addr), 32'(it.addr));
      end
      hs_count++;
      if (first_hs_k < 0) first_hs_k = k;
    end
    if (s_done) begin
      done_count++;
      done_k = k;
    end
    if (s_busy) last_busy_k = k;
    prev_stall = s_valid && !ready;
    prev_data  = s_data;
    prev_rst   = rst;
    @(posedge clk);
    #1;
    k++;
    case (ready_mode)
      0:       ready = 1'b1;
      1:       ready = ~ready;
      default: ready = ready;
    endcase
  endtask

  task automatic push_range(input int first, input int last);
    sb_item_t it;
    for (int r = first; r <= last; r++) begin
      for (int b = 0; b < 4; b++) begin
        it.data = bank[r][8*b +: 8];
        it.addr = 5'(r);
        sb_q.push_back(it);
      end
    end
  endtask

  // Start is high for the cycle ending at edge t; k counts cycles after t.
  task automatic start_dump(input int which);
    sel = which; k = 0; done_count = 0; done_k = -1;
    last_busy_k = -1; first_hs_k = -1; hs_count = 0;
    case (which)
      0:       start0 = 1'b1;
      1:       start1 = 1'b1;
      default: start2 = 1'b1;
    endcase
    cycle();
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
  endtask

  task automatic finish_dump(input int exp_done_k, input int budget);
    int n = 0;
    while (done_count == 0 && n < budget) begin
      cycle();
      n++;
    end
    check("done_in_budget", 32'(done_count != 0), 32'd1);
    repeat (2) cycle();
    check("done_count", 32'(done_count), 32'd1);
    if (exp_done_k >= 0) check("done_cycle", 32'(done_k), 32'(exp_done_k));
    check("busy_fall", 32'(last_busy_k), 32'(done_k));
    check("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    int dc;
    rst = 1'b1; ready = 1'b1; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    for (int i = 0; i < 32; i++) bank[i] = 32'(i) * 32'h01010101;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_valid", 32'(v1), 32'd0);
    check("rst_data", 32'(d1), 32'd0);
    check("rst_addr", 32'(addr1), 32'd0);
    check("rst_busy_one", 32'(busy0), 32'd0);
    check("rst_valid_pair", 32'(v2), 32'd0);
    rst = 1'b0;
    cycle();

    // Full default range with ready tied high.
    push_range(0, 31);
    start_dump(1);
    finish_dump(161, 400);
    check("full_bytes", 32'(hs_count), 32'd128);
    check("full_first_byte", 32'(first_hs_k), 32'd2);

    // Single register x1.
    bank[1] = 32'h11223344;
    push_range(1, 1);
    start_dump(0);
    finish_dump(6, 50);
    check("one_first_byte", 32'(first_hs_k), 32'd2);
    check("one_bytes", 32'(hs_count), 32'd4);

    // Registers 2..3 with ready toggling.
    push_range(2, 3);
    ready_mode = 1;
    start_dump(2);
    finish_dump(-1, 100);
    check("pair_bytes", 32'(hs_count), 32'd8);
    ready_mode = 0;
    ready = 1'b1;

    // Overwrite x5 while its snapshot is stalled in SEND.
    push_range(0, 31);
    start_dump(1);
    n = 0;
    while (!(s_valid && s_addr == 5'd5) && n < 200) begin
      cycle();
      n++;
    end
    check("x5_reached", 32'(s_valid && s_addr == 5'd5), 32'd1);
    ready_mode = 2;
    ready = 1'b0;
    bank[5] = 32'hDEADBEEF;
    repeat (3) cycle();
    ready_mode = 0;
    ready = 1'b1;
    finish_dump(164, 400);

    // Next dump sees the new x5 value.
    push_range(0, 31);
    start_dump(1);
    finish_dump(161, 400);

    // Start pulsed mid-dump is ignored.
    push_range(0, 31);
    start_dump(1);
    repeat (48) cycle();
    start1 = 1'b1;
    cycle();
    start1 = 1'b0;
    finish_dump(161, 400);

    // Reset after the second byte of x3.
    push_range(0, 31);
    start_dump(1);
    n = 0;
    while (hs_count < 14 && n < 100) begin
      cycle();
      n++;
    end
    check("reach_x3", 32'(hs_count), 32'd14);
    rst = 1'b1;
    ready_mode = 2;
    ready = 1'b0;
    cycle();
    rst = 1'b0;
    check("midrst_busy", 32'(busy1), 32'd0);
    check("midrst_valid", 32'(v1), 32'd0);
    check("midrst_done", 32'(done1), 32'd0);
    check("midrst_addr", 32'(addr1), 32'd0);
    check("midrst_data", 32'(d1), 32'd0);
    sb_q.delete();
    dc = done_count;
    ready_mode = 0;
    ready = 1'b1;
    repeat (5) cycle();
    check("no_done_after_rst", 32'(done_count), 32'(dc));
    check("idle_after_rst", 32'(s_busy), 32'd0);

    // Fresh start begins again at FIRST_REG.
    push_range(0, 31);
    start_dump(1);
    finish_dump(161, 400);
    check("restart_first_byte", 32'(first_hs_k), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
